add_sub_arbiter: RTL and testbench
==================================

// Module: add_sub_arbiter
// PURPOSE
//  Two-requester scheduler for the shared sign-magnitude add_sub datapath in the calculator.
//  Picks one request per slot and latches its operands and op. Drives the external add_sub
//  (a1, b1, Add_Sub), registers sf/sign, then returns the result with a 1-cycle ack to the winner.
//  Sits between the operand sources (keypad path = req0, memory/recall path = req1) and add_sub.
// PARAMETERS
//  W     3  operand width, sign-magnitude: [W-1]=sign, [W-2:0]=magnitude; result magnitude is W bits
//  FAIR  1  1 = round-robin between req0/req1; 0 = fixed priority, req0 always wins
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  req0       in   1  requester 0 wants an operation; held high until ack0
//  a0, b0     in   W  requester 0 operands (sign-magnitude)
//  op0        in   1  requester 0 op: 0 = a+b, 1 = a-b
//  req1       in   1  requester 1 request (same rules as req0)
//  a1, b1     in   W  requester 1 operands
//  op1        in   1  requester 1 op
//  ack0       out  1  1-cycle pulse: result valid for requester 0
//  ack1       out  1  1-cycle pulse: result valid for requester 1
//  res_mag    out  W  result magnitude; valid while ack0|ack1, held until next ack
//  res_sign   out  1  result sign; forced 0 when res_mag==0 (no negative zero)
//  busy       out  1  high in EXEC and RESP
//  dp_a       out  W  to add_sub a1
//  dp_b       out  W  to add_sub b1
//  dp_addsub  out  1  to add_sub Add_Sub
//  dp_sf      in   W  from add_sub sf (combinational from dp_*)
//  dp_sign    in   1  from add_sub sign
// BEHAVIOUR
//  Reset: state=IDLE, ack0=ack1=0, res_mag=0, res_sign=0, busy=0, dp_a=dp_b=0, dp_addsub=0,
//   last_grant=1 (req0 favoured first). Reset mid-operation aborts it: no ack is issued.
//  FSM IDLE -> EXEC -> RESP -> IDLE. All outputs registered.
//   IDLE: if req0|req1, select the winner; latch its a/b/op into dp_a/dp_b/dp_addsub and the
//     winner id; -> EXEC. Otherwise stay, dp_* held at 0.
//   EXEC: busy=1; dp_* stable; sample dp_sf->res_mag and dp_sign->res_sign (sign cleared if
//     dp_sf==0); -> RESP.
//   RESP: ack of the winner =1 for exactly this cycle; busy=1; last_grant<=winner; dp_* cleared
//     to 0; -> IDLE.
//  Latency: req high in IDLE cycle N -> ack in cycle N+2. Max rate is 1 op per 3 cycles.
//  Arbitration: only one req high -> it wins. Both high: FAIR=1 grants the one not equal to
//   last_grant; FAIR=0 grants req0.
//  Requests are sampled only in IDLE. Operands need to be stable only in the grant cycle;
//   later changes are ignored.
//  A req still high in the IDLE cycle after its ack is a new request; requesters drop req the
//   cycle they see ack.
//  If the winner drops req after the grant, the op still completes and ack is still pulsed.
//  Arithmetic is done entirely by add_sub. The block never modifies the magnitude; it only
//   normalises -0 to +0.
// STRUCTURE
//  calc_pkg: state enum {IDLE, EXEC, RESP}, OP_ADD=1'b0, OP_SUB=1'b1, REQ0/REQ1 ids.
//  Sub-module rr_arbiter2: comb grant from req0, req1, last_grant and FAIR.
//  The FSM, operand/result registers and last_grant update stay in add_sub_arbiter.
//  add_sub is not instantiated inside; it is connected at the calculator top.
// TESTING (bench instantiates add_sub on dp_*; W=3)
//  1 Reset: rst high 2 cycles with req0=1 -> all outputs 0, no ack; after release ack0 arrives
//    exactly 2 cycles after the first IDLE sample.
//  2 req0 only, a0=3'b011(+3), b0=3'b111(-3), op0=ADD -> ack0 at N+2, res_mag=0, res_sign=0.
//  3 req1 only, a1=3'b101(-1), b1=3'b010(+2), op1=SUB -> ack1 at N+2, res_mag=3, res_sign=1.
//  4 req0 & req1 held high, FAIR=1 -> acks alternate ack0,ack1,ack0,ack1 every 3 cycles;
//    FAIR=0 -> only ack0.
//  5 Grant to req0, then a0 changes and req0 drops in EXEC -> ack0 still pulses with the
//    latched result; no ack1.
//  6 rst asserted in EXEC -> no ack; state IDLE next cycle; the first grant after reset goes to
//    req0 when both requesters are high.
//  Exhaustive pass: all 64 a/b pairs x both ops through req0 and req1, checked against the
//    sign-magnitude model.

Source files
------------

// File: rtl/add_sub_arbiter_pkg.sv
// Shared types and constants for the add_sub scheduler: FSM states, op codes,
// requester ids and the result sign normalisation helper.
package add_sub_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // A zero magnitude is always reported as positive.
  function automatic logic norm_sign(input logic mag_zero, input logic sign);
    return mag_zero ? 1'b0 : sign;
  endfunction

endpackage

// File: rtl/add_sub_arbiter_rr_arbiter2.sv
// Two-way grant selection: a lone requester always wins; on contention either
// alternate against the last grant (FAIR=1) or always favour requester 0.
module rr_arbiter2
  import add_sub_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  // Combinational winner selection
  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    o_gnt_id    = REQ0;
    if (i_req0 && i_req1) begin
      o_gnt_id = FAIR ? ~i_last_grant : REQ0;
    end else if (i_req1) begin
      o_gnt_id = REQ1;
    end else begin
      o_gnt_id = REQ0;
    end
  end

endmodule

// File: rtl/add_sub_arbiter.sv
// Schedules requester 0 (keypad) and requester 1 (memory recall) onto the shared
// external add_sub datapath and returns each result with a one-cycle ack.
module add_sub_arbiter
  import add_sub_arbiter_pkg::*;
#(
  parameter int W    = 3,
  parameter bit FAIR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         op0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         op1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] res_mag,
  output logic         res_sign,
  output logic         busy,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic         dp_addsub,
  input  logic [W-1:0] dp_sf,
  input  logic         dp_sign
);

  state_t       r_state;
  logic         r_winner;
  logic         r_last_grant;
  logic         r_ack0;
  logic         r_ack1;
  logic         r_busy;
  logic [W-1:0] r_res_mag;
  logic         r_res_sign;
  logic [W-1:0] r_dp_a;
  logic [W-1:0] r_dp_b;
  logic         r_dp_addsub;

  logic         w_gnt_valid;
  logic         w_gnt_id;
  logic [W-1:0] w_sel_a;
  logic [W-1:0] w_sel_b;
  logic         w_sel_op;
  logic         w_sf_zero;

  rr_arbiter2 #(
    .FAIR (FAIR)
  ) u_arb (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last_grant (r_last_grant),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_id     (w_gnt_id)
  );

  // Operand mux towards the datapath registers
  always_comb begin
    w_sel_a  = a0;
    w_sel_b  = b0;
    w_sel_op = op0;
    if (w_gnt_id == REQ1) begin
      w_sel_a  = a1;
      w_sel_b  = b1;
      w_sel_op = op1;
    end else begin
      w_sel_a  = a0;
      w_sel_b  = b0;
      w_sel_op = op0;
    end
  end

  assign w_sf_zero = (dp_sf == {W{1'b0}});

  // Scheduler FSM with operand, result and fairness registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_winner     <= REQ0;
      r_last_grant <= REQ1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
      r_res_mag    <= {W{1'b0}};
      r_res_sign   <= 1'b0;
      r_dp_a       <= {W{1'b0}};
      r_dp_b       <= {W{1'b0}};
      r_dp_addsub  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (w_gnt_valid) begin
            r_dp_a      <= w_sel_a;
            r_dp_b      <= w_sel_b;
            r_dp_addsub <= w_sel_op;
            r_winner    <= w_gnt_id;
            r_busy      <= 1'b1;
            r_state     <= EXEC;
          end else begin
            r_dp_a      <= {W{1'b0}};
            r_dp_b      <= {W{1'b0}};
            r_dp_addsub <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        EXEC: begin
          r_res_mag  <= dp_sf;
          r_res_sign <= norm_sign(w_sf_zero, dp_sign);
          r_ack0     <= (r_winner == REQ0);
          r_ack1     <= (r_winner == REQ1);
          r_busy     <= 1'b1;
          r_state    <= RESP;
        end
        RESP: begin
          r_ack0       <= 1'b0;
          r_ack1       <= 1'b0;
          r_busy       <= 1'b0;
          r_last_grant <= r_winner;
          r_dp_a       <= {W{1'b0}};
          r_dp_b       <= {W{1'b0}};
          r_dp_addsub  <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_ack0      <= 1'b0;
          r_ack1      <= 1'b0;
          r_busy      <= 1'b0;
          r_dp_a      <= {W{1'b0}};
          r_dp_b      <= {W{1'b0}};
          r_dp_addsub <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign res_mag   = r_res_mag;
  assign res_sign  = r_res_sign;
  assign busy      = r_busy;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_addsub = r_dp_addsub;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: a fair and a fixed-priority instance share stimulus,
// each driving its own sign-magnitude add_sub stand-in; results vs an integer model.
module tb_add_sub_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1, op0, op1;
  logic [2:0] a0, b0, a1, b1;

  logic       ack0_f, ack1_f, res_sign_f, busy_f, dp_addsub_f, dp_sign_f;
  logic [2:0] res_mag_f, dp_a_f, dp_b_f, dp_sf_f;
  logic       ack0_p, ack1_p, res_sign_p, busy_p, dp_addsub_p, dp_sign_p;
  logic [2:0] res_mag_p, dp_a_p, dp_b_p, dp_sf_p;

  int errors = 0;
  int checks = 0;
  int last_f = 1;
  int last_p = 1;

  // Stand-in for the external add_sub: sign-magnitude add of a and (+/-)b.
  function automatic logic [3:0] add_sub_fn(input logic [2:0] a, input logic [2:0] b,
                                            input logic sub);
    logic sa, sb, sg;
    logic [1:0] ma, mb;
    logic [2:0] mag;
    sa = a[2]; sb = b[2] ^ sub; ma = a[1:0]; mb = b[1:0];
    if (sa == sb) begin
      mag = {1'b0, ma} + {1'b0, mb}; sg = sa;
    end else if (ma > mb) begin
      mag = {1'b0, ma - mb}; sg = sa;
    end else begin
      mag = {1'b0, mb - ma}; sg = sb;
    end
    return {sg, mag};
  endfunction

  function automatic int sm_val(input logic [2:0] x);
    return x[2] ? -int'(x[1:0]) : int'(x[1:0]);
  endfunction

  // Reference: plain integer arithmetic, then magnitude and sign ({sign, mag}).
  function automatic logic [3:0] ref_calc(input logic [2:0] a, input logic [2:0] b,
                                          input logic op);
    int r;
    int m;
    r = op ? (sm_val(a) - sm_val(b)) : (sm_val(a) + sm_val(b));
    m = (r < 0) ? -r : r;
    return {(r < 0), m[2:0]};
  endfunction

  assign {dp_sign_f, dp_sf_f} = add_sub_fn(dp_a_f, dp_b_f, dp_addsub_f);
  assign {dp_sign_p, dp_sf_p} = add_sub_fn(dp_a_p, dp_b_p, dp_addsub_p);

  add_sub_arbiter #(.W(3), .FAIR(1'b1)) dut_f (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .ack0(ack0_f), .ack1(ack1_f), .res_mag(res_mag_f), .res_sign(res_sign_f),
    .busy(busy_f), .dp_a(dp_a_f), .dp_b(dp_b_f), .dp_addsub(dp_addsub_f),
    .dp_sf(dp_sf_f), .dp_sign(dp_sign_f)
  );

  add_sub_arbiter #(.W(3), .FAIR(1'b0)) dut_p (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .ack0(ack0_p), .ack1(ack1_p), .res_mag(res_mag_p), .res_sign(res_sign_p),
    .busy(busy_p), .dp_a(dp_a_p), .dp_b(dp_b_p), .dp_addsub(dp_addsub_p),
    .dp_sf(dp_sf_p), .dp_sign(dp_sign_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation from an IDLE cycle with the current req/operands; model picks winners.
  task automatic run_op(input bit hold);
    int wf, wp;
    logic [3:0] ef, ep;
    logic [2:0] ea;
    if (!req0 && !req1) begin
      tick();
      chk("idle_acks", 32'({ack1_f, ack0_f, ack1_p, ack0_p}), 32'd0);
      chk("idle_busy", 32'({busy_f, busy_p}), 32'd0);
      return;
    end
    wf = (req0 && req1) ? ((last_f == 0) ? 1 : 0) : (req1 ? 1 : 0);
    wp = (req0 && req1) ? 0 : (req1 ? 1 : 0);
    ef = (wf == 1) ? ref_calc(a1, b1, op1) : ref_calc(a0, b0, op0);
    ep = (wp == 1) ? ref_calc(a1, b1, op1) : ref_calc(a0, b0, op0);
    ea = (wf == 1) ? a1 : a0;
    tick();
    chk("exec_busy", 32'({busy_f, busy_p}), 32'd3);
    chk("exec_noack", 32'({ack1_f, ack0_f, ack1_p, ack0_p}), 32'd0);
    chk("exec_dp_a", 32'(dp_a_f), 32'(ea));
    tick();
    chk("ack_f", 32'({ack1_f, ack0_f}), (wf == 1) ? 32'd2 : 32'd1);
    chk("res_f", 32'({res_sign_f, res_mag_f}), 32'(ef));
    chk("ack_p", 32'({ack1_p, ack0_p}), (wp == 1) ? 32'd2 : 32'd1);
    chk("res_p", 32'({res_sign_p, res_mag_p}), 32'(ep));
    chk("resp_busy", 32'({busy_f, busy_p}), 32'd3);
    last_f = wf;
    last_p = wp;
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    tick();
    chk("post_acks", 32'({ack1_f, ack0_f, ack1_p, ack0_p}), 32'd0);
    chk("post_dp", 32'({dp_a_f, dp_b_f, dp_addsub_f}), 32'd0);
  endtask

  initial begin
    logic [3:0] e5;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
    a0 = 3'b001; b0 = 3'b001; op0 = 1'b0;
    a1 = 3'b000; b1 = 3'b000; op1 = 1'b0;

    // 1: reset held two cycles with req0 high
    tick();
    tick();
    chk("rst_acks", 32'({ack1_f, ack0_f, ack1_p, ack0_p}), 32'd0);
    chk("rst_busy", 32'({busy_f, busy_p}), 32'd0);
    chk("rst_res", 32'({res_sign_f, res_mag_f}), 32'd0);
    chk("rst_dp", 32'({dp_a_f, dp_b_f, dp_addsub_f}), 32'd0);
    rst = 1'b0;
    run_op(1'b0);

    // 2: +3 + -3 -> +0
    req0 = 1'b1; a0 = 3'b011; b0 = 3'b111; op0 = 1'b0;
    run_op(1'b0);
    chk("zero_sign_held", 32'({res_sign_f, res_mag_f}), 32'd0);

    // 3: -1 - +2 -> -3
    req1 = 1'b1; a1 = 3'b101; b1 = 3'b010; op1 = 1'b1;
    run_op(1'b0);

    // 4: both held high for four operations
    req0 = 1'b1; a0 = 3'b001; b0 = 3'b010; op0 = 1'b0;
    req1 = 1'b1; a1 = 3'b110; b1 = 3'b001; op1 = 1'b1;
    for (int i = 0; i < 4; i++) run_op(i < 3);

    // 5: operands change and req0 drops during EXEC
    req0 = 1'b1; a0 = 3'b010; b0 = 3'b001; op0 = 1'b1;
    e5 = ref_calc(a0, b0, op0);
    tick();
    chk("t5_busy", 32'(busy_f), 32'd1);
    a0 = 3'b111; req0 = 1'b0;
    tick();
    chk("t5_ack", 32'({ack1_f, ack0_f}), 32'd1);
    chk("t5_res", 32'({res_sign_f, res_mag_f}), 32'(e5));
    tick();
    chk("t5_noack", 32'({ack1_f, ack0_f}), 32'd0);
    chk("t5_res_held", 32'({res_sign_f, res_mag_f}), 32'(e5));
    last_f = 0; last_p = 0;

    // 6: reset during EXEC aborts, then contention goes to req0
    req0 = 1'b1; a0 = 3'b011; b0 = 3'b001; op0 = 1'b0;
    tick();
    rst = 1'b1; req1 = 1'b1;
    tick();
    chk("t6_acks", 32'({ack1_f, ack0_f, ack1_p, ack0_p}), 32'd0);
    chk("t6_busy", 32'({busy_f, busy_p}), 32'd0);
    chk("t6_dp", 32'({dp_a_f, dp_b_f, dp_addsub_f}), 32'd0);
    rst = 1'b0;
    last_f = 1; last_p = 1;
    tick();
    chk("t6_noack_after", 32'({ack1_f, ack0_f}), 32'd0);
    chk("t6_gnt_dp_a", 32'(dp_a_f), 32'(a0));
    tick();
    chk("t6_first_ack0", 32'({ack1_f, ack0_f}), 32'd1);
    last_f = 0; last_p = 0;
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Exhaustive: every operand pair and op through each requester
    for (int r = 0; r < 2; r++) begin
      for (int op = 0; op < 2; op++) begin
        for (int a = 0; a < 8; a++) begin
          for (int b = 0; b < 8; b++) begin
            if (r == 0) begin
              req0 = 1'b1; a0 = 3'(a); b0 = 3'(b); op0 = 1'(op);
            end else begin
              req1 = 1'b1; a1 = 3'(a); b1 = 3'(b); op1 = 1'(op);
            end
            run_op(1'b0);
          end
        end
      end
    end

    // Random request patterns and operands
    for (int i = 0; i < 80; i++) begin
      req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
      a0 = 3'($urandom_range(0, 7)); b0 = 3'($urandom_range(0, 7));
      a1 = 3'($urandom_range(0, 7)); b1 = 3'($urandom_range(0, 7));
      op0 = 1'($urandom_range(0, 1)); op1 = 1'($urandom_range(0, 1));
      run_op(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
